seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_if.sv | 21 ++
 rtl/seven_seg_scanner.sv | 108 ++++++++++
 tb/tb_seven_seg_scanner.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Host-side bundle for the seven-segment scanner: capture strobe and data in, status and pad drives out.
// The scanner takes the slave view; whoever loads values takes the master view.
interface seven_seg_scanner_if;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        ready;
    logic        frame_done;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;

    modport master (
        output value, dp, load,
        input  ready, frame_done, io_sel, io_seg
    );

    modport slave (
        input  value, dp, load,
        output ready, frame_done, io_sel, io_seg
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-seg driver, outputs registered (1 cycle); load never stalls, last load wins, swap only at frame end.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero digits 3..1.
module seven_seg_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_scanner_if.slave bus
);
    localparam int             CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend_vld;
    logic [3:0]    sel_q;
    logic [7:0]    seg_q;
    logic          fd_q;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nib;
    logic [7:0]    seg_next;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == 2'd3);

    always_comb begin
        nib      = disp_val[{idx, 2'b00} +: 4];
        seg_next = {~disp_dp[idx], hex_seg(nib)};
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero only if it and every digit to its left are zero.
        if (idx != 2'd0 && (disp_val >> {idx, 2'b00}) == 16'h0000 && !disp_dp[idx])
            seg_next = 8'hFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= 2'd0;
            disp_val <= 16'h0000;
            disp_dp  <= 4'h0;
            pend_val <= 16'h0000;
            pend_dp  <= 4'h0;
            pend_vld <= 1'b0;
            sel_q    <= 4'hF;
            seg_q    <= 8'hFF;
            fd_q     <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // The older pending value goes live at the boundary even if a new load lands in the same cycle.
            if (frame_end && pend_vld) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp;
                pend_vld <= 1'b1;
            end else if (frame_end) begin
                pend_vld <= 1'b0;
            end

            sel_q <= (cnt < BLANK_LIM) ? 4'hF : ~(4'b0001 << idx);
            seg_q <= seg_next;
            fd_q  <= frame_end;
        end
    end

    assign bus.ready      = ~pend_vld;
    assign bus.frame_done = fd_q;
    assign bus.io_sel     = sel_q;
    assign bus.io_seg     = seg_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: expected digit windows are queued per frame and popped as the DUT scans them.
module tb_seven_seg_scanner;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scanner_if io ();

    seven_seg_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (io)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_sel;
    int         en_run, blank_run, fd_gap;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] d, input int n);
        logic [15:0] upper;
        logic [3:0]  nb;
        logic [7:0]  s;
        upper = v >> (4 * n);
        nb    = upper[3:0];
        s     = HEX[nb];
        s[7]  = ~d[n];
`ifdef LEADING_ZERO_BLANK_EN
        if (n > 0 && upper == 16'h0000 && !d[n]) s = 8'hFF;
`endif
        return s;
    endfunction

    task automatic expect_frame(input logic [15:0] v, input logic [3:0] d);
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            e.sel = ~(4'b0001 << n);
            e.seg = exp_seg(v, d, n);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard side: pops one expectation per enabled digit window and checks slot timing.
    always @(negedge clk) begin
        if (mon_en) begin
            if (io.io_sel != 4'hF) begin
                if (prev_sel == 4'hF) begin
                    check("blank_len", 16'(blank_run), 16'(BLANK));
                    check("exp_avail", 16'(exp_q.size() > 0), 16'd1);
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    en_run = 0;
                end
                en_run++;
                check("io_sel", 16'(io.io_sel), 16'(cur.sel));
                check("io_seg", 16'(io.io_seg), 16'(cur.seg));
            end else begin
                if (prev_sel != 4'hF) begin
                    check("enable_len", 16'(en_run), 16'(SCAN_DIV - BLANK));
                    blank_run = 0;
                end
                blank_run++;
            end
            fd_gap++;
            if (io.frame_done) begin
                check("frame_period", 16'(fd_gap), 16'(FRAME));
                fd_gap = 0;
            end
            prev_sel = io.io_sel;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (!io.load) begin
            io.value = 16'($urandom);
            io.dp    = 4'($urandom);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        io.value = v;
        io.dp    = d;
        io.load  = 1'b1;
        tick();
        io.load  = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            tick();
            n++;
        end while (io.frame_done !== 1'b1 && n < 2 * FRAME);
        check("frame_done_seen", 16'(io.frame_done), 16'd1);
    endtask

    task automatic start_run();
        exp_q.delete();
        prev_sel  = 4'hF;
        en_run    = 0;
        blank_run = 0;
        fd_gap    = 0;
        expect_frame(16'h0000, 4'h0);
        rst       = 1'b0;
        mon_en    = 1'b1;
    endtask

    initial begin
        io.load  = 1'b0;
        io.value = 16'h0000;
        io.dp    = 4'h0;
        rst      = 1'b1;
        ticks(2);
        check("rst_io_sel", 16'(io.io_sel), 16'h000F);
        check("rst_io_seg", 16'(io.io_seg), 16'h00FF);
        check("rst_ready", 16'(io.ready), 16'd1);
        check("rst_frame_done", 16'(io.frame_done), 16'd0);
        start_run();

        // Idle frame of zeros, then a mid-frame load that must wait for the boundary.
        wait_fd();
        expect_frame(16'h0000, 4'h0);
        ticks(8);
        check("ready_idle", 16'(io.ready), 16'd1);
        do_load(16'h1F80, 4'b0010);
        check("ready_after_load", 16'(io.ready), 16'd0);
        ticks(5);
        check("ready_pending", 16'(io.ready), 16'd0);
        wait_fd();
        check("ready_after_swap", 16'(io.ready), 16'd1);
        expect_frame(16'h1F80, 4'b0010);

        // Two loads in one frame: only the second is shown.
        ticks(4);
        do_load(16'h1111, 4'h0);
        ticks(6);
        do_load(16'h2222, 4'h0);
        wait_fd();
        expect_frame(16'h2222, 4'h0);

        // Load exactly on the boundary cycle while another value is pending.
        ticks(5);
        do_load(16'h1234, 4'h0);
        ticks(25);
        io.value = 16'hABCD;
        io.dp    = 4'h0;
        io.load  = 1'b1;
        tick();
        io.load  = 1'b0;
        check("boundary_hit", 16'(io.frame_done), 16'd1);
        check("ready_boundary_load", 16'(io.ready), 16'd0);
        expect_frame(16'h1234, 4'h0);
        ticks(10);
        check("ready_second_pending", 16'(io.ready), 16'd0);
        wait_fd();
        check("ready_after_second", 16'(io.ready), 16'd1);
        expect_frame(16'hABCD, 4'h0);

        // Reset mid-frame with a pending value and a simultaneous load.
        ticks(10);
        do_load(16'h5678, 4'h0);
        ticks(3);
        mon_en   = 1'b0;
        rst      = 1'b1;
        io.value = 16'h9999;
        io.load  = 1'b1;
        tick();
        io.load  = 1'b0;
        check("midrst_io_sel", 16'(io.io_sel), 16'h000F);
        check("midrst_io_seg", 16'(io.io_seg), 16'h00FF);
        check("midrst_ready", 16'(io.ready), 16'd1);
        check("midrst_frame_done", 16'(io.frame_done), 16'd0);
        start_run();
        wait_fd();
        check("ready_post_rst", 16'(io.ready), 16'd1);
        expect_frame(16'h0000, 4'h0);

        // Leading-zero patterns (blanked only when the feature is built in).
        ticks(6);
        do_load(16'h0050, 4'h0);
        wait_fd();
        expect_frame(16'h0050, 4'h0);
        ticks(7);
        do_load(16'h0000, 4'b1000);
        wait_fd();
        expect_frame(16'h0000, 4'b1000);
        wait_fd();
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
